counter_ctrl: RTL and testbench
===============================

Name: counter_ctrl

Overview:
- Sequencer for the board's free-running LED counter.
- Owns the per-second prescaler and the N-bit LED count.
- Takes single-cycle command pulses from the button front-end (already synchronized and debounced): run/pause, single-step, clear and direction.
- Drives the LEDs directly and exports a tick pulse for downstream consumers.

Parameters:
- CYCLES_PER_TICK, 125_000_000: clk cycles per count advance in RUN; legal range is 1 or more.
- N_LEDS, 4: width of the LED count.

Ports:
- clk  in  1  system clock (125 MHz on board)
- rst  in  1  asynchronous, active-high reset
- btn_run  in  1  1-cycle pulse; toggles RUN/PAUSED
- btn_step  in  1  1-cycle pulse; advances count by one, PAUSED only
- btn_clear  in  1  1-cycle pulse; zeroes count and prescaler
- btn_dir  in  1  1-cycle pulse; toggles count direction
- leds  out  N_LEDS  current count
- running  out  1  high in RUN
- dir_down  out  1  high when counting down
- tick  out  1  registered; high for exactly the cycle in which leds shows a newly advanced value

Behaviour:
- Reset (async, active-high): state=PAUSED, leds=0, prescaler=0, dir_down=0, tick=0, running=0. A reset mid-count discards all state immediately. Outputs hold reset values until the first clk edge after rst deasserts.
- All outputs are registered. A command sampled on edge N is visible after edge N (1-cycle latency).
- States: PAUSED(0) and RUN(1).
  - btn_run toggles the state.
  - The prescaler runs only in RUN and holds its value in PAUSED. Pause then resume continues from the held phase.
- RUN advance rule:
  - The prescaler counts 0..CYCLES_PER_TICK-1.
  - On the edge where it equals CYCLES_PER_TICK-1, it wraps to 0 and the count advances.
  - With CYCLES_PER_TICK=1 the count advances every cycle.
- Count arithmetic:
  - Up: modulo 2^N_LEDS (15 -> 0 for N_LEDS=4).
  - Down: 0 -> 15.
  - No saturation.
- btn_step:
  - In PAUSED: advance once in the current direction. Prescaler unchanged.
  - In RUN: ignored.
- Priority within one cycle (highest first): btn_clear > advance (prescaler wrap or step).
  - btn_clear: leds=0 and prescaler=0. tick stays 0 that cycle.
  - btn_run is applied independently in the same cycle. The state change affects the prescaler from the next cycle on; the current cycle's advance decision uses the old state.
  - btn_dir is applied independently. Any advance in the same cycle uses the old direction.
- tick is asserted the cycle after any advance (wrap or step). It is never asserted on clear, load or reset.

Optional Feature:
- Macro: COUNTER_CTRL_LOAD_EN.
- Defined: adds input ports load (1) and load_value (N_LEDS).
  - load=1 sets leds=load_value on the next edge.
  - Priority: below btn_clear, above advance.
  - A load does not change the prescaler and does not assert tick.
- Undefined: the ports do not exist. Behaviour is identical to the base spec.

Decomposition:
- Package counter_ctrl_pkg holds:
  - state encoding constants ST_PAUSED=1'b0 and ST_RUN=1'b1
  - CYCLES_PER_SECOND=125_000_000
  - a prescaler-width function (ceil log2, minimum 1)
- One sub-module, tick_gen: the prescaler.
  - Inputs: en, clr.
  - Output: wrap, combinational, asserted when en=1 and count=CYCLES_PER_TICK-1.
  - Parameter: CYCLES_PER_TICK.
- counter_ctrl holds the FSM, direction flag, count register and tick register.

Test Plan (sim with CYCLES_PER_TICK=4, N_LEDS=4):
- Reset then btn_run pulse:
  - running=1.
  - leds goes 0->1->2 at every 4th edge after the pulse.
  - tick is high for 1 cycle at each change.
  - leds=1 appears exactly 4 cycles after the pulse edge.
- Pause/resume and step:
  - After leds=2, btn_run pauses, then 10 idle cycles: leds stays 2.
  - btn_step: leds=3 next cycle with tick=1.
  - btn_step pulsed while in RUN: no change.
  - Resume continues with the held prescaler phase.
- Wrap both directions:
  - Counting up, leds goes 14->15->0.
  - btn_dir, then step in PAUSED from 0: leds=15, dir_down=1.
  - Step again: leds=14.
- Simultaneous events:
  - btn_clear on the same edge as a prescaler wrap: leds=0, tick=0, prescaler restarts. Next advance lands 4 cycles later.
  - btn_dir on the wrap edge: that advance uses the old direction.
- Async reset mid-run:
  - Assert rst between clock edges while leds=9, running=1.
  - Outputs drop to 0 immediately, not waiting for an edge.
  - After deassert, stays PAUSED with leds=0.
- With COUNTER_CTRL_LOAD_EN:
  - load=1, load_value=12 in RUN: leds=12, tick=0, prescaler phase unchanged.
  - load and btn_clear together: leds=0.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - shared constants and helpers for the LED counter sequencer
package counter_ctrl_pkg;

    typedef logic state_t;

    localparam state_t ST_PAUSED = 1'b0;
    localparam state_t ST_RUN    = 1'b1;

    localparam int CYCLES_PER_SECOND = 125_000_000;

    // Bits needed to hold 0..cycles-1; never narrower than one bit.
    function automatic int prescaler_width(input int cycles);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < cycles) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/counter_ctrl_tick_gen.sv
// rtl/counter_ctrl_tick_gen.sv - per-tick prescaler with combinational wrap strobe
module tick_gen
    import counter_ctrl_pkg::*;
#(
    parameter int CYCLES_PER_TICK = CYCLES_PER_SECOND
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam int W = prescaler_width(CYCLES_PER_TICK);
    localparam logic [W-1:0] LAST = W'(CYCLES_PER_TICK - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] count;
    logic         at_last;

    assign at_last = (count == LAST);
    assign wrap    = en && at_last;

    // Phase is held while disabled so a paused counter resumes where it left off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (at_last) begin
                count <= '0;
            end else begin
                count <= count + ONE;
            end
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - LED counter sequencer; COUNTER_CTRL_LOAD_EN adds load/load_value
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int CYCLES_PER_TICK = CYCLES_PER_SECOND,
    parameter int N_LEDS          = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_run,
    input  logic              btn_step,
    input  logic              btn_clear,
    input  logic              btn_dir,
    output logic [N_LEDS-1:0] leds,
    output logic              running,
    output logic              dir_down,
    output logic              tick
`ifdef COUNTER_CTRL_LOAD_EN
    ,
    input  logic              load,
    input  logic [N_LEDS-1:0] load_value
`endif
);

    localparam logic [N_LEDS-1:0] ONE = N_LEDS'(1);

    state_t            state;
    state_t            state_next;
    logic              run_en;
    logic              wrap;
    logic              advance;
    logic              load_req;
    logic [N_LEDS-1:0] load_data;
    logic [N_LEDS-1:0] count;
    logic [N_LEDS-1:0] count_next;
    logic              dir_q;
    logic              tick_q;

`ifdef COUNTER_CTRL_LOAD_EN
    assign load_req  = load;
    assign load_data = load_value;
`else
    assign load_req  = 1'b0;
    assign load_data = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_PAUSED;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_PAUSED: if (btn_run) state_next = ST_RUN;
            ST_RUN:    if (btn_run) state_next = ST_PAUSED;
            default:   state_next = ST_PAUSED;
        endcase
    end

    always_comb begin
        run_en  = 1'b0;
        running = 1'b0;
        case (state)
            ST_RUN: begin
                run_en  = 1'b1;
                running = 1'b1;
            end
            default: begin
                run_en  = 1'b0;
                running = 1'b0;
            end
        endcase
    end

    tick_gen #(
        .CYCLES_PER_TICK(CYCLES_PER_TICK)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (run_en),
        .clr  (btn_clear),
        .wrap (wrap)
    );

    // Advance decision and direction both use this cycle's registered state.
    assign advance = run_en ? wrap : btn_step;

    always_comb begin
        count_next = count;
        if (btn_clear) begin
            count_next = '0;
        end else if (load_req) begin
            count_next = load_data;
        end else if (advance) begin
            count_next = dir_q ? (count - ONE) : (count + ONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            dir_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            count  <= count_next;
            dir_q  <= dir_q ^ btn_dir;
            tick_q <= advance && !btn_clear && !load_req;
        end
    end

    assign leds     = count;
    assign dir_down = dir_q;
    assign tick     = tick_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - scoreboard bench for counter_ctrl (CYCLES_PER_TICK=4, N_LEDS=4)
module tb_counter_ctrl;

    localparam int CPT = 4;
    localparam int N   = 4;
`ifdef COUNTER_CTRL_LOAD_EN
    localparam logic LOAD_ON = 1'b1;
`else
    localparam logic LOAD_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         btn_run = 1'b0;
    logic         btn_step = 1'b0;
    logic         btn_clear = 1'b0;
    logic         btn_dir = 1'b0;
    logic [N-1:0] leds;
    logic         running;
    logic         dir_down;
    logic         tick;
`ifdef COUNTER_CTRL_LOAD_EN
    logic         load = 1'b0;
    logic [N-1:0] load_value = '0;
`endif

    always #5 clk = ~clk;

    counter_ctrl #(
        .CYCLES_PER_TICK(CPT),
        .N_LEDS(N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_run    (btn_run),
        .btn_step   (btn_step),
        .btn_clear  (btn_clear),
        .btn_dir    (btn_dir),
        .leds       (leds),
        .running    (running),
        .dir_down   (dir_down),
        .tick       (tick)
`ifdef COUNTER_CTRL_LOAD_EN
        ,
        .load       (load),
        .load_value (load_value)
`endif
    );

    typedef struct packed {
        logic [N-1:0] leds;
        logic         running;
        logic         dir_down;
        logic         tick;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int errors = 0;

    logic         m_run;
    logic         m_dir;
    logic         m_tick;
    logic [N-1:0] m_leds;
    int           m_pre;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_dir  = 1'b0;
        m_tick = 1'b0;
        m_leds = '0;
        m_pre  = 0;
    endtask

    task automatic cycle(input logic r, input logic s, input logic c, input logic d,
                         input logic l, input logic [N-1:0] lv);
        logic adv;
        logic ld;
        exp_t e;
        exp_t got;
        ld        = l & LOAD_ON;
        btn_run   = r;
        btn_step  = s;
        btn_clear = c;
        btn_dir   = d;
`ifdef COUNTER_CTRL_LOAD_EN
        load       = l;
        load_value = lv;
`endif
        adv = m_run ? (m_pre == CPT - 1) : s;
        if (c)        m_leds = '0;
        else if (ld)  m_leds = lv;
        else if (adv) m_leds = m_dir ? (m_leds - 1'b1) : (m_leds + 1'b1);
        m_tick = adv && !c && !ld;
        if (c)          m_pre = 0;
        else if (m_run) m_pre = (m_pre == CPT - 1) ? 0 : m_pre + 1;
        m_run = m_run ^ r;
        m_dir = m_dir ^ d;
        e = '{leds: m_leds, running: m_run, dir_down: m_dir, tick: m_tick};
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        btn_run   = 1'b0;
        btn_step  = 1'b0;
        btn_clear = 1'b0;
        btn_dir   = 1'b0;
`ifdef COUNTER_CTRL_LOAD_EN
        load = 1'b0;
`endif
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            check("sb_leds", leds, got.leds);
            check("sb_running", running, got.running);
            check("sb_dir_down", dir_down, got.dir_down);
            check("sb_tick", tick, got.tick);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic run_until_leds(input logic [N-1:0] target, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_leds == target) begin
                found = 1'b1;
                break;
            end
            idle(1);
        end
        check(tag, found, 1);
    endtask

    task automatic run_until_last_phase(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m_pre == CPT - 1) begin
                found = 1'b1;
                break;
            end
            idle(1);
        end
        check(tag, found, 1);
    endtask

    initial begin
        int gap;
        model_reset();

        #3;
        check("rst_leds", leds, 0);
        check("rst_running", running, 0);
        check("rst_dir", dir_down, 0);
        check("rst_tick", tick, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // First advance lands four edges after the run pulse.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("run_on", running, 1);
        idle(3);
        check("pre_first_leds", leds, 0);
        idle(1);
        check("first_leds", leds, 1);
        check("first_tick", tick, 1);
        idle(1);
        check("tick_one_cycle", tick, 0);
        idle(3);
        check("second_leds", leds, 2);

        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        idle(10);
        check("paused_hold", leds, 2);
        check("paused_running", running, 0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        check("step_leds", leds, 3);
        check("step_tick", tick, 1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        idle(1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        idle(8);

        // Up-count wrap, then reverse and step down through zero.
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        run_until_leds(4'd14, "wait_14");
        run_until_leds(4'd0, "wait_wrap0");
        check("wrap_up", leds, 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        check("wrap_down_leds", leds, 15);
        check("wrap_down_dir", dir_down, 1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        check("step_down_leds", leds, 14);

        // Clear coinciding with a wrap, then direction change on a wrap.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        run_until_last_phase("wait_phase_clr");
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        check("clr_wrap_leds", leds, 0);
        check("clr_wrap_tick", tick, 0);
        gap = 0;
        do begin
            idle(1);
            gap++;
        end while (tick == 1'b0 && gap < 20);
        check("clr_gap", gap, 4);
        check("clr_next_leds", leds, 15);
        run_until_last_phase("wait_phase_dir");
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        check("dir_wrap_leds", leds, 14);
        check("dir_wrap_dir", dir_down, 0);

        // Asynchronous reset between edges while running at 9.
        run_until_leds(4'd9, "wait_9");
        check("pre_rst_running", running, 1);
        #2 rst = 1'b1;
        #1;
        check("async_leds", leds, 0);
        check("async_running", running, 0);
        check("async_tick", tick, 0);
        check("async_dir", dir_down, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
        idle(5);
        check("post_rst_leds", leds, 0);
        check("post_rst_running", running, 0);

`ifdef COUNTER_CTRL_LOAD_EN
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        idle(1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd12);
        check("load_leds", leds, 12);
        check("load_tick", tick, 0);
        idle(2);
        check("load_phase_leds", leds, 13);
        idle(4);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5);
        check("load_clr_leds", leds, 0);
`endif

        for (int i = 0; i < 120; i++) begin
            cycle($urandom_range(5) == 0, $urandom_range(3) == 0, $urandom_range(9) == 0,
                  $urandom_range(7) == 0, $urandom_range(9) == 0, 4'($urandom_range(15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
